// File: rtl/inv_permutation.sv
// inv_permutation: inverse Keccak rho-pi lane permutation with buffered read/write sequencing.
module inv_permutation #(
  parameter int LANE_W = 64,
  parameter int LANES = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LANE_W-1:0] in_lane,
  output logic              read_input,
  output logic [4:0]        in_addr,
  output logic [LANE_W-1:0] out_lane,
  output logic              write_output,
  output logic [4:0]        out_addr,
  output logic              ready
);
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, READ = 3'd2, WRITE = 3'd3, FINISH = 3'd4;
  localparam logic [5:0] ROT [25] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };
  logic [2:0] state;
  logic [4:0] cnt, x, y, src;
  logic [LANE_W-1:0] mem [LANES];
  logic [2*LANE_W-1:0] dbl;
  logic cout;
  assign cout = cnt == 5'(LANES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:   state <= start ? INIT : IDLE;
        INIT: begin
          cnt <= '0;
          state <= start ? INIT : READ;
        end
        READ: begin
          cnt <= cout ? 5'd0 : cnt + 5'd1;
          state <= cout ? WRITE : READ;
        end
        WRITE: begin
          cnt <= cout ? cnt : cnt + 5'd1;
          state <= cout ? FINISH : WRITE;
        end
        FINISH: state <= start ? INIT : FINISH;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst && state == READ) mem[cnt] <= in_lane;
  // Output lane (x,y) comes from permuted lane (X=y, Y=(2x+3y) mod 5), rotated back right.
  always_comb begin
    x = cnt % 5'd5;
    y = cnt / 5'd5;
    src = y + 5'd5 * ((5'd2 * x + 5'd3 * y) % 5'd5);
    dbl = {mem[src], mem[src]} >> ROT[cnt];
    read_input = state == READ;
    write_output = state == WRITE;
    ready = state == FINISH;
    in_addr = read_input ? cnt : 5'd0;
    out_addr = write_output ? cnt : 5'd0;
    out_lane = write_output ? dbl[LANE_W-1:0] : '0;
  end
endmodule

// File: tb/tb_inv_permutation.sv
// tb_inv_permutation: scoreboard bench feeding forward rho-pi states and expecting the originals back.
module tb_inv_permutation;
  logic clk, rst, start;
  logic [63:0] in_lane, out_lane;
  logic read_input, write_output, ready;
  logic [4:0] in_addr, out_addr;
  inv_permutation dut (
    .clk(clk), .rst(rst), .start(start), .in_lane(in_lane),
    .read_input(read_input), .in_addr(in_addr), .out_lane(out_lane),
    .write_output(write_output), .out_addr(out_addr), .ready(ready)
  );
  int n_checks = 0, n_errors = 0;
  int cyc = 0, t_rd = 0, rd_n = 0, wr_n = 0;
  bit seen_rd = 0;
  logic [63:0] p_cur [25], p_in [25], a_exp [25];
  logic [68:0] q [$];
  logic [68:0] e;
  int r_tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign in_lane = read_input ? p_cur[in_addr] : 64'h0;
  function automatic logic [63:0] rol(input logic [63:0] v, input int r);
    return r == 0 ? v : (v << r) | (v >> (64 - r));
  endfunction
  task automatic fwd();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p_in[y + 5 * ((2 * x + 3 * y) % 5)] = rol(a_exp[x + 5 * y], r_tab[x + 5 * y]);
  endtask
  task automatic clear();
    for (int k = 0; k < 25; k++) begin
      p_in[k] = 64'h0;
      a_exp[k] = 64'h0;
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (read_input && !seen_rd) begin
      t_rd = cyc;
      seen_rd = 1;
    end
    rd_n += int'(read_input);
    wr_n += int'(write_output);
    if (!read_input) begin
      n_checks++;
      assert (in_addr === 5'd0) else begin n_errors++; $error("FAIL in_addr_idle: got %0d want 0", in_addr); end
    end
    if (write_output) begin
      n_checks++;
      assert (q.size() > 0) else begin n_errors++; $error("FAIL sb_empty: got unexpected lane %0d want none", out_addr); end
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        assert ({out_addr, out_lane} === e) else begin
          n_errors++;
          $error("FAIL lane: got %0d:%h want %0d:%h", out_addr, out_lane, e[68:64], e[63:0]);
        end
      end
    end else begin
      n_checks++;
      assert (out_addr === 5'd0 && out_lane === 64'h0) else begin
        n_errors++;
        $error("FAIL out_idle: got %0d:%h want 0:0", out_addr, out_lane);
      end
    end
  end
  task automatic load_and_start(input int sc);
    for (int k = 0; k < 25; k++) q.push_back({5'(k), a_exp[k]});
    for (int k = 0; k < 25; k++) p_cur[k] = p_in[k];
    seen_rd = 0;
    rd_n = 0;
    wr_n = 0;
    start = 1;
    for (int i = 0; i < sc; i++) begin
      @(posedge clk); #1;
      n_checks++;
      assert (!read_input && !write_output && !ready) else begin
        n_errors++;
        $error("FAIL init_hold: got rd=%b wr=%b rdy=%b want 0 0 0", read_input, write_output, ready);
      end
    end
    start = 0;
  endtask
  task automatic finish_txn(input bit tog);
    int i;
    i = 0;
    while (!ready && i < 200) begin
      @(posedge clk); #1;
      i++;
      start = (tog && (read_input || write_output)) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    n_checks++;
    assert (ready === 1'b1) else begin n_errors++; $error("FAIL ready_timeout: got %b want 1", ready); end
    n_checks++;
    assert (rd_n == 25 && wr_n == 25) else begin n_errors++; $error("FAIL phase_len: got rd=%0d wr=%0d want 25 25", rd_n, wr_n); end
    n_checks++;
    assert (cyc - t_rd == 50) else begin n_errors++; $error("FAIL latency: got %0d want 50", cyc - t_rd); end
    n_checks++;
    assert (q.size() == 0) else begin n_errors++; $error("FAIL sb_left: got %0d want 0", q.size()); end
    q.delete();
  endtask
  initial begin
    rst = 1;
    start = 0;
    clear();
    for (int k = 0; k < 25; k++) p_cur[k] = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    assert (!read_input && !write_output && !ready && out_lane === 64'h0) else begin
      n_errors++;
      $error("FAIL reset: got rd=%b wr=%b rdy=%b lane=%h want 0", read_input, write_output, ready, out_lane);
    end
    rst = 0;
    repeat (20) begin
      @(posedge clk); #1;
      n_checks++;
      assert (!read_input && !write_output && !ready) else begin
        n_errors++;
        $error("FAIL idle: got rd=%b wr=%b rdy=%b want 0 0 0", read_input, write_output, ready);
      end
    end
    clear(); p_in[10] = 64'h2; a_exp[1] = 64'h1;
    load_and_start(1); finish_txn(0);
    clear(); p_in[1] = 64'h1; a_exp[6] = 64'h0000_0000_0010_0000;
    load_and_start(3); finish_txn(0);
    clear(); p_in[0] = 64'hDEAD_BEEF_0000_0001; a_exp[0] = 64'hDEAD_BEEF_0000_0001;
    load_and_start(1); finish_txn(1);
    clear(); p_in[24] = '1; p_in[12] = 64'h8000_0000_0000_0000;
    a_exp[21] = '1; a_exp[13] = 64'h0000_0040_0000_0000;
    load_and_start(2); finish_txn(0);
    clear(); a_exp[24] = 64'h1; a_exp[14] = 64'h8000_0000_0000_0000; a_exp[20] = '1; fwd();
    load_and_start(1); finish_txn(0);
    for (int k = 0; k < 25; k++) a_exp[k] = {$urandom, $urandom};
    fwd();
    load_and_start(1);
    for (int i = 0; i < 100 && !(write_output && out_addr == 5'd7); i++) begin @(posedge clk); #1; end
    n_checks++;
    assert (write_output && out_addr === 5'd7) else begin n_errors++; $error("FAIL reach_w7: got %0d want 7", out_addr); end
    rst = 1;
    @(posedge clk); #1;
    n_checks++;
    assert (!read_input && !write_output && !ready && out_lane === 64'h0 && out_addr === 5'd0) else begin
      n_errors++;
      $error("FAIL mid_reset: got rd=%b wr=%b rdy=%b addr=%0d want all 0", read_input, write_output, ready, out_addr);
    end
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    @(posedge clk); #1;
    n_checks++;
    assert (!read_input && !write_output && !ready) else begin n_errors++; $error("FAIL post_reset: got rd=%b wr=%b want 0 0", read_input, write_output); end
    for (int t = 0; t < 100; t++) begin
      for (int k = 0; k < 25; k++) a_exp[k] = {$urandom, $urandom};
      fwd();
      load_and_start(1 + (t % 3));
      finish_txn(t[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
